// File: rtl/i2c_target.sv
// I2C target, 7-bit address, 2-byte payload; SCL/SDA oversampled on clk through a sync + stability filter.
// Latency: bus edges seen 2+FILT clk late; SDA changes 1 clk after filtered SCL fall; wvalid 1 clk after the final ACK ends.
// Backpressure: none; no clock stretching, wdata/wvalid must be taken on the strobe.
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h11,
    parameter int         FILT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            SCL,
    inout  tri              SDA,
    input  logic [1:0][7:0] rdata,
    output logic [1:0][7:0] wdata,
    output logic            wvalid,
    output logic            busy
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WR, S_RD, S_IGN} state_t;

    state_t          state, state_nx;
    logic [1:0]      s1, s2, filt;          // bit 1 = SCL, bit 0 = SDA
    logic [1:0][3:0] fcnt;
    logic            scl_d, sda_d;
    logic            scl_rise, scl_fall, start, stop;
    logic [3:0]      bitcnt;
    logic            ackph;                 // inside the ACK slot (bit 8)
    logic [1:0]      bytecnt;
    logic [7:0]      shreg, tx_next;
    logic [1:0][7:0] shadow;
    logic            sda_oe;
    logic            match;

    assign SDA = sda_oe ? 1'b0 : 1'bz;

    // A level change only passes once the synced input has differed for FILT clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 2'b11;
            s2    <= 2'b11;
            filt  <= 2'b11;
            fcnt  <= '0;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            s1    <= {SCL, SDA};
            s2    <= s1;
            scl_d <= filt[1];
            sda_d <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == 4'(FILT - 1)) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 4'd1;
                end
            end
        end
    end

    assign scl_rise = filt[1] & ~scl_d;
    assign scl_fall = ~filt[1] & scl_d;
    assign start    = filt[1] & scl_d & sda_d & ~filt[0];
    assign stop     = filt[1] & scl_d & ~sda_d & filt[0];
    assign match    = (shreg[7:1] == ADDR);

    always_comb begin
        tx_next = 8'hFF;
        if (bytecnt == 2'd0)
            tx_next = shadow[1];
        else if (bytecnt == 2'd1)
            tx_next = shadow[0];
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (stop) begin
            state_nx = S_IDLE;
        end else if (start) begin
            state_nx = S_ADDR;
        end else begin
            case (state)
                S_ADDR: if (scl_fall && !ackph && bitcnt == 4'd8)
                            state_nx = match ? (shreg[0] ? S_RD : S_WR) : S_IGN;
                S_WR:   if (scl_fall && !ackph && bitcnt == 4'd8 && bytecnt == 2'd2)
                            state_nx = S_IGN;
                S_RD:   if (scl_rise && ackph && filt[0])
                            state_nx = S_IGN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt  <= '0;
            ackph   <= 1'b0;
            bytecnt <= '0;
            shreg   <= '0;
            shadow  <= '0;
            sda_oe  <= 1'b0;
            wdata   <= '0;
            wvalid  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            wvalid <= 1'b0;
            if (stop) begin
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start) begin
                bitcnt  <= '0;
                ackph   <= 1'b0;
                bytecnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_ADDR, S_WR: begin
                        if (scl_rise && !ackph && bitcnt != 4'd8) begin
                            shreg  <= {shreg[6:0], filt[0]};
                            bitcnt <= bitcnt + 4'd1;
                        end
                        if (scl_fall) begin
                            if (ackph) begin
                                ackph  <= 1'b0;
                                bitcnt <= '0;
                                sda_oe <= 1'b0;
                                if (state == S_WR && bytecnt == 2'd2) begin
                                    wdata  <= shadow;
                                    wvalid <= 1'b1;
                                end
                            end else if (bitcnt == 4'd8) begin
                                if (state == S_ADDR) begin
                                    if (match) begin
                                        sda_oe <= 1'b1;
                                        ackph  <= 1'b1;
                                        shadow <= rdata;
                                        busy   <= 1'b1;
                                    end
                                end else if (bytecnt != 2'd2) begin
                                    if (bytecnt == 2'd0)
                                        shadow[1] <= shreg;
                                    else
                                        shadow[0] <= shreg;
                                    bytecnt <= bytecnt + 2'd1;
                                    sda_oe  <= 1'b1;
                                    ackph   <= 1'b1;
                                end
                            end
                        end
                    end
                    S_RD: begin
                        if (scl_rise && !ackph && bitcnt != 4'd8) begin
                            shreg  <= {shreg[6:0], 1'b1};
                            bitcnt <= bitcnt + 4'd1;
                        end
                        if (scl_fall) begin
                            if (ackph) begin
                                ackph  <= 1'b0;
                                bitcnt <= '0;
                                shreg  <= tx_next;
                                sda_oe <= ~tx_next[7];
                            end else if (bitcnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                ackph  <= 1'b1;
                                if (bytecnt != 2'd2)
                                    bytecnt <= bytecnt + 2'd1;
                            end else if (bitcnt != 4'd0) begin
                                sda_oe <= ~shreg[7];
                            end
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end
endmodule
